// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet constants, receiver FSM encoding and the fixed-field table
// used by the ARP receive and transmit paths.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
    localparam logic [15:0] ARP_OP_REQ    = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY  = 16'd2;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam logic [6:0]  MIN_FRAME_LEN = 7'd64;
    localparam logic [6:0]  LEN_SAT       = 7'd127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_ARP,
        ST_TAIL,
        ST_COMMIT,
        ST_DROP
    } arp_state_e;

    typedef struct packed {
        logic       check;
        logic [7:0] value;
    } fixed_byte_t;

    // Bytes whose value is fully fixed for an Ethernet/IPv4 ARP frame, by offset from dst MAC.
    function automatic fixed_byte_t fixed_byte(input logic [6:0] off);
        fixed_byte_t fb;
        fb.check = 1'b1;
        fb.value = '0;
        case (off)
            7'd12:   fb.value = ETH_TYPE_ARP[15:8];
            7'd13:   fb.value = ETH_TYPE_ARP[7:0];
            7'd14:   fb.value = ARP_HTYPE_ETH[15:8];
            7'd15:   fb.value = ARP_HTYPE_ETH[7:0];
            7'd16:   fb.value = ARP_PTYPE_IP[15:8];
            7'd17:   fb.value = ARP_PTYPE_IP[7:0];
            7'd18:   fb.value = 8'd6;
            7'd19:   fb.value = 8'd4;
            7'd20:   fb.value = ARP_OP_REQ[15:8];
            default: fb.check = 1'b0;
        endcase
        return fb;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
module crc32_d8
    import arp_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // NOTE: blocking assignments here are intentional; each bit step feeds the next
    // within the same evaluation, which is exactly what combinational logic needs.
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ data[i]) ? CRC_POLY_REFL : 32'h0);
        end
    end

endmodule

// File: rtl/arp_rx_cache.sv
// ARP receiver: parses GMII byte frames, validates format and CRC, reports requests
// and learns peer IP->MAC bindings into a small FIFO-replaced cache with a lookup port.
module arp_rx_cache
    import arp_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int LEARN_REQ    = 1,
    parameter int ACCEPT_BCAST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        lookup_req,
    input  logic [31:0] lookup_ip,
    output logic        lookup_done,
    output logic        lookup_hit,
    output logic [47:0] lookup_mac,
    output logic        arp_req_valid,
    output logic [47:0] peer_mac,
    output logic [31:0] peer_ip,
    output logic        rx_done,
    output logic        rx_err
);

    localparam int PW = $clog2(DEPTH);

    arp_state_e  state, state_next;
    logic [6:0]  cnt;
    logic [31:0] crc, crc_next;
    logic        mac_local_ok, mac_bc_ok, op_req;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [23:0] tip;

    fixed_byte_t fb;
    logic [7:0]  mac_byte;
    logic        local_match, bc_match, byte_bad, frame_ok, learn_ok;
    logic        done_set, err_set, wr_en, start_byte;

    crc32_d8 u_crc (.crc(crc), .data(rx_data), .crc_next(crc_next));

    assign start_byte = rx_valid && (rx_data == 8'h55);
    assign frame_ok   = (cnt >= MIN_FRAME_LEN) && (crc == CRC_RESIDUE);
    assign learn_ok   = (!op_req || (LEARN_REQ != 0)) && (sip != '0);

    // A byte is bad if it breaks dst MAC, a fixed field, the opcode or the target IP.
    always_comb begin
        fb       = fixed_byte(cnt);
        mac_byte = '0;
        for (int i = 0; i < 6; i++) begin
            if (cnt == 7'(i)) mac_byte = local_mac[8*(5-i) +: 8];
        end
        local_match = mac_local_ok && (rx_data == mac_byte);
        bc_match    = (ACCEPT_BCAST != 0) && mac_bc_ok && (rx_data == 8'hFF);
        byte_bad    = 1'b0;
        if (cnt < 7'd6)
            byte_bad = !(local_match || bc_match);
        else if (fb.check)
            byte_bad = (rx_data != fb.value);
        else if (cnt == 7'd21)
            byte_bad = (rx_data != ARP_OP_REQ[7:0]) && (rx_data != ARP_OP_REPLY[7:0]);
        else if (cnt == 7'd41)
            byte_bad = ({tip, rx_data} != local_ip);
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        err_set    = 1'b0;
        wr_en      = 1'b0;
        case (state)
            ST_IDLE: if (start_byte) state_next = ST_PRE;
            ST_PRE: begin
                if (!rx_valid) begin
                    err_set    = 1'b1;
                    state_next = ST_IDLE;
                end else if (rx_data == 8'hD5)
                    state_next = ST_HDR;
                else if (rx_data != 8'h55 || cnt == 7'd7)
                    state_next = ST_DROP;
            end
            ST_HDR, ST_ARP: begin
                if (!rx_valid) begin
                    err_set    = 1'b1;
                    state_next = ST_IDLE;
                end else if (byte_bad)
                    state_next = ST_DROP;
                else if (cnt == 7'd13)
                    state_next = ST_ARP;
                else if (cnt == 7'd41)
                    state_next = ST_TAIL;
            end
            ST_TAIL: if (!rx_valid) state_next = ST_COMMIT;
            ST_COMMIT: begin
                done_set   = frame_ok;
                err_set    = !frame_ok;
                wr_en      = frame_ok && learn_ok;
                // The idle gap before a back-to-back frame is spent in TAIL, so its first
                // preamble byte can already arrive here.
                state_next = start_byte ? ST_PRE : ST_IDLE;
            end
            ST_DROP: begin
                if (!rx_valid) begin
                    err_set    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            crc          <= '1;
            mac_local_ok <= 1'b0;
            mac_bc_ok    <= 1'b0;
            op_req       <= 1'b0;
            smac         <= '0;
            sip          <= '0;
            tip          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_COMMIT: if (start_byte) cnt <= 7'd1;
                ST_PRE: begin
                    if (rx_valid && rx_data == 8'hD5) begin
                        cnt          <= '0;
                        crc          <= '1;
                        mac_local_ok <= 1'b1;
                        mac_bc_ok    <= 1'b1;
                    end else if (rx_valid) begin
                        cnt <= cnt + 7'd1;
                    end
                end
                ST_HDR, ST_ARP, ST_TAIL: begin
                    if (rx_valid) begin
                        crc <= crc_next;
                        if (cnt != LEN_SAT) cnt <= cnt + 7'd1;
                        if (cnt < 7'd6) begin
                            mac_local_ok <= local_match;
                            mac_bc_ok    <= bc_match;
                        end
                        if (cnt == 7'd21) op_req <= (rx_data == ARP_OP_REQ[7:0]);
                        if (cnt >= 7'd22 && cnt <= 7'd27) smac <= {smac[39:0], rx_data};
                        if (cnt >= 7'd28 && cnt <= 7'd31) sip <= {sip[23:0], rx_data};
                        if (cnt >= 7'd38 && cnt <= 7'd40) tip <= {tip[15:0], rx_data};
                    end
                end
                default: ;
            endcase
        end
    end

    logic [DEPTH-1:0] ent_valid;
    logic [31:0]      ent_ip  [DEPTH];
    logic [47:0]      ent_mac [DEPTH];
    logic [PW-1:0]    ptr, sip_idx, wr_idx;
    logic             sip_hit, lk_hit;
    logic [47:0]      lk_mac;

    // Entries are unique by IP, so at most one compare fires for each search.
    always_comb begin
        sip_hit = 1'b0;
        sip_idx = '0;
        lk_hit  = 1'b0;
        lk_mac  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_ip[i] == sip) begin
                sip_hit = 1'b1;
                sip_idx = PW'(i);
            end
            if (ent_valid[i] && ent_ip[i] == lookup_ip) begin
                lk_hit = 1'b1;
                lk_mac = ent_mac[i];
            end
        end
    end

    assign wr_idx = sip_hit ? sip_idx : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ptr       <= '0;
        end else if (wr_en) begin
            ent_valid[wr_idx] <= 1'b1;
            if (!sip_hit) ptr <= ptr + 1'b1;
        end
    end

    // NOTE: the IP/MAC storage has no reset; the valid bits alone gate every use of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_ip[wr_idx]  <= sip;
            ent_mac[wr_idx] <= smac;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done       <= 1'b0;
            rx_err        <= 1'b0;
            arp_req_valid <= 1'b0;
            peer_mac      <= '0;
            peer_ip       <= '0;
            lookup_done   <= 1'b0;
            lookup_hit    <= 1'b0;
            lookup_mac    <= '0;
        end else begin
            rx_done       <= done_set;
            rx_err        <= err_set;
            arp_req_valid <= done_set && op_req;
            if (done_set) begin
                peer_mac <= smac;
                peer_ip  <= sip;
            end
            lookup_done <= lookup_req;
            lookup_hit  <= lookup_req && lk_hit;
            lookup_mac  <= (lookup_req && lk_hit) ? lk_mac : '0;
        end
    end

endmodule
